// File: rtl/cdr_pkg.sv
// Shared CDR definitions: vote encoding, default phase-interpolator geometry
// and a saturating adder used by the loop filter integrator.
package cdr_pkg;

    localparam int unsigned CDR_CODE_W = 7;
    localparam int unsigned CDR_FRAC_W = 8;

    typedef logic signed [1:0] vote_t;

    localparam vote_t VOTE_UP   = 2'sb01;
    localparam vote_t VOTE_NULL = 2'sb00;
    localparam vote_t VOTE_DN   = 2'sb11;

    // Symmetric clamp to +/-lim; the sum is formed one bit wider so it cannot overflow.
    function automatic logic signed [31:0] sat_add(
        input logic signed [31:0] a,
        input logic signed [31:0] b,
        input logic signed [31:0] lim
    );
        logic signed [32:0] s;
        s = 33'(a) + 33'(b);
        if (s > 33'(lim)) begin
            return lim;
        end else if (s < -33'(lim)) begin
            return -lim;
        end else begin
            return s[31:0];
        end
    endfunction

endpackage

// File: rtl/cdr_loop_filter_if.sv
// Phase-detector vote inputs and phase-interpolator outputs of the CDR loop filter.
interface cdr_loop_filter_if
    import cdr_pkg::*;
#(
    parameter int unsigned CODE_W = CDR_CODE_W,
    parameter int unsigned INT_W  = 12
);
    logic                     en;
    logic                     up;
    logic                     dn;
    logic [CODE_W-1:0]        pi_code;
    logic                     pi_code_vld;
    logic signed [INT_W-1:0]  freq_int;
    logic                     lock;

    modport master (output en, up, dn, input pi_code, pi_code_vld, freq_int, lock);
    modport slave  (input en, up, dn, output pi_code, pi_code_vld, freq_int, lock);
endinterface

// File: rtl/cdr_vote_decim.sv
// Maps early/late votes to +1/0/-1 and decimates them into one decision per
// DECIM qualified votes. The decision is combinational on the window's last vote.
module cdr_vote_decim
    import cdr_pkg::*;
#(
    parameter int unsigned DECIM = 8
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  en,
    input  logic  up,
    input  logic  dn,
    output vote_t dec,
    output logic  dec_vld
);
    localparam int unsigned CNT_W = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int unsigned SUM_W = CNT_W + 1;
    localparam int unsigned TOT_W = SUM_W + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DECIM - 1);

    logic [CNT_W-1:0]        cnt_d, cnt_q;
    logic signed [SUM_W-1:0] sum_d, sum_q;
    logic signed [TOT_W-1:0] total_s;
    vote_t                   vote_s;

    // Vote mapping; both-high is a null vote just like both-low.
    always_comb begin
        case ({up, dn})
            2'b10:   vote_s = VOTE_UP;
            2'b01:   vote_s = VOTE_DN;
            default: vote_s = VOTE_NULL;
        endcase
    end

    // Window counter, running sum and end-of-window decision.
    always_comb begin
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        dec     = VOTE_NULL;
        dec_vld = 1'b0;
        // The total can reach +/-DECIM, hence one bit wider than the stored sum.
        total_s = TOT_W'(sum_q) + TOT_W'(vote_s);
        if (en) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d   = '0;
                sum_d   = '0;
                dec_vld = 1'b1;
                if (total_s[TOT_W-1]) begin
                    dec = VOTE_DN;
                end else if (total_s != '0) begin
                    dec = VOTE_UP;
                end else begin
                    dec = VOTE_NULL;
                end
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
                sum_d = sum_q + SUM_W'(vote_s);
            end
        end else begin
            cnt_d = cnt_q;
            sum_d = sum_q;
        end
    end

    // Window state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            sum_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            sum_q <= sum_d;
        end
    end

endmodule

// File: rtl/cdr_loop_filter.sv
// CDR digital loop filter: decimated bang-bang decisions drive a P+I phase
// accumulator and a dither-based lock detector. Macro CDR_LF_INTEGRAL_EN builds
// the frequency integrator (second-order loop); without it the loop is first-order.
module cdr_loop_filter
    import cdr_pkg::*;
#(
    parameter int unsigned DECIM    = 8,
    parameter int unsigned CODE_W   = CDR_CODE_W,
    parameter int unsigned FRAC_W   = CDR_FRAC_W,
    parameter int unsigned INT_W    = 12,
    parameter int unsigned KP_SHIFT = 6,
    parameter int unsigned LOCK_CNT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    cdr_loop_filter_if.slave  bus
);
    localparam int unsigned ACC_W  = CODE_W + FRAC_W;
    localparam int unsigned LCNT_W = $clog2(LOCK_CNT + 1);
    localparam logic [LCNT_W-1:0] LOCK_MAX = LCNT_W'(LOCK_CNT);

    vote_t                   dec_s;
    logic                    dec_vld_s;
    logic signed [INT_W-1:0] freq_int_s;

    vote_t                   d_d, d_q;
    logic                    upd_d, upd_q;
    logic [LCNT_W-1:0]       lock_cnt_d, lock_cnt_q;
    logic                    lock_d, lock_q;
    logic [ACC_W-1:0]        phase_acc_d, phase_acc_q;
    logic                    pi_code_vld_d, pi_code_vld_q;

    cdr_vote_decim #(.DECIM(DECIM)) u_decim (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (bus.en),
        .up      (bus.up),
        .dn      (bus.dn),
        .dec     (dec_s),
        .dec_vld (dec_vld_s)
    );

`ifdef CDR_LF_INTEGRAL_EN
    localparam logic signed [31:0] INT_LIM = (32'sd1 <<< (INT_W - 1)) - 32'sd1;

    logic signed [INT_W-1:0] freq_int_d, freq_int_q;

    // Frequency integrator, updated on the window-closing edge.
    always_comb begin
        if (dec_vld_s) begin
            freq_int_d = INT_W'(sat_add(32'(freq_int_q), 32'(dec_s), INT_LIM));
        end else begin
            freq_int_d = freq_int_q;
        end
    end

    // Integrator register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            freq_int_q <= '0;
        end else begin
            freq_int_q <= freq_int_d;
        end
    end

    assign freq_int_s = freq_int_q;
`else
    assign freq_int_s = '0;
`endif

    // Decision capture and lock counting on the window-closing edge; d_q doubles
    // as the previous decision for the next window's lock comparison.
    always_comb begin
        upd_d      = dec_vld_s;
        d_d        = d_q;
        lock_cnt_d = lock_cnt_q;
        if (dec_vld_s) begin
            d_d = dec_s;
            if ((dec_s != VOTE_NULL) && (dec_s == d_q)) begin
                lock_cnt_d = '0;
            end else if (lock_cnt_q != LOCK_MAX) begin
                lock_cnt_d = lock_cnt_q + LCNT_W'(1);
            end else begin
                lock_cnt_d = lock_cnt_q;
            end
        end else begin
            d_d        = d_q;
            lock_cnt_d = lock_cnt_q;
        end
        lock_d = (lock_cnt_d == LOCK_MAX);
    end

    // Phase accumulator one edge after the decision, using the updated integrator;
    // modulo wrap is how the PI code rolls across UI boundaries.
    always_comb begin
        pi_code_vld_d = upd_q;
        if (upd_q) begin
            phase_acc_d = phase_acc_q + (ACC_W'(d_q) << KP_SHIFT) + ACC_W'(freq_int_s);
        end else begin
            phase_acc_d = phase_acc_q;
        end
    end

    // Decision, lock and phase registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_q           <= VOTE_NULL;
            upd_q         <= 1'b0;
            lock_cnt_q    <= '0;
            lock_q        <= 1'b0;
            phase_acc_q   <= '0;
            pi_code_vld_q <= 1'b0;
        end else begin
            d_q           <= d_d;
            upd_q         <= upd_d;
            lock_cnt_q    <= lock_cnt_d;
            lock_q        <= lock_d;
            phase_acc_q   <= phase_acc_d;
            pi_code_vld_q <= pi_code_vld_d;
        end
    end

    assign bus.pi_code     = phase_acc_q[ACC_W-1:FRAC_W];
    assign bus.pi_code_vld = pi_code_vld_q;
    assign bus.freq_int    = freq_int_s;
    assign bus.lock        = lock_q;

endmodule

// File: tb/tb_cdr_loop_filter.sv
// Scoreboard bench for cdr_loop_filter: a behavioural loop model queues the
// expected state and strobe cycle for each window; strobes are checked on arrival.
module tb_cdr_loop_filter;

    localparam int DECIM    = 8;
    localparam int CODE_W   = 7;
    localparam int FRAC_W   = 8;
    localparam int INT_W    = 12;
    localparam int KP_SHIFT = 6;
    localparam int LOCK_CNT = 16;
    localparam int ACC_W    = CODE_W + FRAC_W;
    localparam int INT_LIM  = (1 << (INT_W - 1)) - 1;

`ifdef CDR_LF_INTEGRAL_EN
    localparam int LATE_ACC  = 266;
    localparam int LATE_FREQ = 4;
    localparam int WRAP_ACC  = 32703;
    localparam int WRAP_FREQ = -1;
`else
    localparam int LATE_ACC  = 256;
    localparam int LATE_FREQ = 0;
    localparam int WRAP_ACC  = 32704;
    localparam int WRAP_FREQ = 0;
`endif

    typedef struct {
        int acc;
        int freq;
        int lock;
        int cyc;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   cyc   = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    int   m_cnt, m_sum, m_freq, m_acc, m_lockc, m_dprev;
    exp_t sb[$];

    cdr_loop_filter_if #(.CODE_W(CODE_W), .INT_W(INT_W)) bus ();

    cdr_loop_filter #(
        .DECIM(DECIM), .CODE_W(CODE_W), .FRAC_W(FRAC_W),
        .INT_W(INT_W), .KP_SHIFT(KP_SHIFT), .LOCK_CNT(LOCK_CNT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp_v, cyc);
        end
    endtask

    task automatic m_reset();
        m_cnt = 0; m_sum = 0; m_freq = 0; m_acc = 0; m_lockc = 0; m_dprev = 0;
        sb.delete();
    endtask

    // Drive one cycle of votes, let the edge sample them, then advance the model.
    task automatic step(input logic e, input logic u, input logic d);
        int v;
        int tot;
        int dec;
        bus.en = e; bus.up = u; bus.dn = d;
        @(posedge clk);
        #1;
        if (e) begin
            v = (u && !d) ? 1 : ((d && !u) ? -1 : 0);
            if (m_cnt == DECIM - 1) begin
                tot = m_sum + v;
                dec = (tot > 0) ? 1 : ((tot < 0) ? -1 : 0);
                m_cnt = 0;
                m_sum = 0;
`ifdef CDR_LF_INTEGRAL_EN
                m_freq = m_freq + dec;
                if (m_freq > INT_LIM) m_freq = INT_LIM;
                if (m_freq < -INT_LIM) m_freq = -INT_LIM;
`endif
                if (dec != 0 && dec == m_dprev) m_lockc = 0;
                else if (m_lockc < LOCK_CNT) m_lockc++;
                m_dprev = dec;
                m_acc = (m_acc + dec * (1 << KP_SHIFT) + m_freq) & ((1 << ACC_W) - 1);
                sb.push_back('{m_acc, m_freq, (m_lockc == LOCK_CNT) ? 1 : 0, cyc + 1});
            end else begin
                m_cnt++;
                m_sum += v;
            end
        end
    endtask

    task automatic idle(input int n);
        bus.en = 1'b0; bus.up = 1'b0; bus.dn = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic window(input logic u, input logic d);
        repeat (DECIM) step(1'b1, u, d);
    endtask

    // Assert reset between edges while still voting late, then release cleanly.
    task automatic mid_reset(input string tag);
        bus.en = 1'b1; bus.up = 1'b1; bus.dn = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        chk({tag, "_pi_code"}, 32'(bus.pi_code), 0);
        chk({tag, "_vld"}, 32'(bus.pi_code_vld), 0);
        chk({tag, "_freq"}, 32'(bus.freq_int), 0);
        chk({tag, "_lock"}, 32'(bus.lock), 0);
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.pi_code_vld === 1'b1) begin
            chk("vld_expected", (sb.size() > 0) ? 1 : 0, 1);
            if (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("vld_cycle", cyc, e.cyc);
                chk("pi_code", 32'(bus.pi_code), e.acc >> FRAC_W);
                chk("phase_acc", 32'(dut.phase_acc_q), e.acc);
                chk("freq_int", 32'(bus.freq_int), e.freq);
                chk("lock", 32'(bus.lock), e.lock);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.en = 1'b0; bus.up = 1'b0; bus.dn = 1'b0;
        m_reset();
        #1 rst_n = 1'b0;
        #1;
        chk("rst_pi_code", 32'(bus.pi_code), 0);
        chk("rst_vld", 32'(bus.pi_code_vld), 0);
        chk("rst_freq", 32'(bus.freq_int), 0);
        chk("rst_lock", 32'(bus.lock), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Constant late votes for four windows.
        repeat (4) window(1'b1, 1'b0);
        idle(2);
        chk("late_acc", 32'(dut.phase_acc_q), LATE_ACC);
        chk("late_freq", 32'(bus.freq_int), LATE_FREQ);
        chk("late_pi_code", 32'(bus.pi_code), 1);
        chk("late_lock", 32'(bus.lock), 0);

        // Reset part-way through a window; first strobe timing checked by the scoreboard.
        repeat (3) step(1'b1, 1'b1, 1'b0);
        mid_reset("mid_rst");

        // Wrap below zero from reset.
        window(1'b0, 1'b1);
        idle(2);
        chk("wrap_acc", 32'(dut.phase_acc_q), WRAP_ACC);
        chk("wrap_pi_code", 32'(bus.pi_code), 127);
        chk("wrap_freq", 32'(bus.freq_int), WRAP_FREQ);

        // Null votes, then a tied window.
        window(1'b1, 1'b1);
        repeat (4) step(1'b1, 1'b1, 1'b0);
        repeat (4) step(1'b1, 1'b0, 1'b1);
        idle(2);
        chk("tie_pi_code", 32'(bus.pi_code), 127);

        // Alternating decisions build lock; a repeated decision drops it.
        @(posedge clk);
        mid_reset("lock_rst");
        for (int k = 1; k <= LOCK_CNT; k++) begin
            if (k % 2 == 1) window(1'b1, 1'b0);
            else            window(1'b0, 1'b1);
            if (k == LOCK_CNT - 1) chk("lock_pre", 32'(bus.lock), 0);
        end
        chk("lock_set", 32'(bus.lock), 1);
        window(1'b1, 1'b0);
        chk("lock_hold", 32'(bus.lock), 1);
        window(1'b1, 1'b0);
        chk("lock_drop", 32'(bus.lock), 0);

        // Freeze for five cycles mid-window: window end slips accordingly.
        repeat (3) step(1'b1, 1'b1, 1'b0);
        repeat (5) step(1'b0, 1'b1, 1'b0);
        repeat (5) step(1'b1, 1'b1, 1'b0);

        // Mixed random traffic with gaps in en.
        repeat (6 * DECIM) step(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        idle(4);

        chk("sb_drain", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/cdr_loop_filter.md
# cdr_loop_filter

Digital loop filter for the receive CDR. It consumes the per-UI early/late votes from the bang-bang phase detector and decimates them into one decision per window. A second-order (proportional + integral) phase accumulator then produces the phase-interpolator code that steers the recovered sampling clock. A lock indicator flags when decisions dither around the data eye centre.

## Interface
- DECIM, 8: votes per decision window (≥2).
- CODE_W, 7: phase-interpolator code width (2^CODE_W phases per UI).
- FRAC_W, 8: fractional bits below the PI code in the phase accumulator.
- INT_W, 12: signed frequency-integrator width. Constraint: INT_W ≤ CODE_W+FRAC_W.
- KP_SHIFT, 6: proportional gain. Each decision adds ±2^KP_SHIFT fractional LSBs.
- LOCK_CNT, 16: count of qualifying consecutive decisions needed to assert lock.
- clk, input, 1: recovered/sampling clock, one vote per cycle.
- rst_n, input, 1: asynchronous, active-low reset.
- en, input, 1: vote qualifier. When low, votes are ignored and the window is frozen.
- up, input, 1: late vote from the phase detector.
- dn, input, 1: early vote from the phase detector.
- pi_code, output, CODE_W: phase-interpolator code.
- pi_code_vld, output, 1: one-cycle strobe on each pi_code update.
- freq_int, output, INT_W: signed frequency integrator, for observation.
- lock, output, 1: loop lock indicator.

## Operation
- **Vote mapping** (each cycle with en=1):
  - up&~dn → +1.
  - dn&~up → −1.
  - Both 0 or both 1 → 0. Both high is treated as a null vote.
- **Window:**
  - Window counter runs 0..DECIM−1 and advances only when en=1.
  - Signed vote sum width is $clog2(DECIM)+1.
- **Window end:** on the en=1 cycle with count=DECIM−1, compute total = sum + current vote.
  - Decision d = +1 if total>0, −1 if total<0, 0 on a tie.
  - Sum and counter clear.
- **Integral path:** freq_int ← sat(freq_int + d).
  - Saturation limits are ±(2^(INT_W−1)−1).
- **Proportional + integral:** phase_acc (CODE_W+FRAC_W bits, unsigned) ← phase_acc + d·2^KP_SHIFT + sext(freq_int).
  - Arithmetic is modulo 2^(CODE_W+FRAC_W); wrap-around in either direction is intended.
  - pi_code = phase_acc[CODE_W+FRAC_W−1 : FRAC_W].
- **Lock:**
  - lock_cnt increments (saturating at LOCK_CNT) when d is 0 or differs from the previous window's d.
  - lock_cnt clears when d is nonzero and equal to the previous d.
  - lock = (lock_cnt == LOCK_CNT).
  - The previous d resets to 0.
- **en low:** in-flight updates from an already-closed window still complete.
- **Reset values:** all state and outputs are 0: pi_code=0, pi_code_vld=0, freq_int=0, lock=0.

## Timing
- **Edge E** samples the last vote of a window and registers d, freq_int and lock_cnt.
- **Edge E+1** updates phase_acc and pi_code using the post-E freq_int. pi_code_vld is high for the cycle following E+1.
- **Vote-to-pi_code latency** is 2 clk edges.
- **Back-to-back windows:** the next window's first vote is sampled at E+1 with no dead cycle.
- pi_code_vld pulses every window, including when d=0.
- **Reset asserted mid-window:** all state clears immediately. The first window after release starts at count 0.

## Configuration
- **Macro CDR_LF_INTEGRAL_EN:**
  - Defined: second-order loop as above.
  - Undefined: first-order loop. The integrator is not built, freq_int is tied to 0, and phase_acc adds only d·2^KP_SHIFT.
  - Window, wrap and lock behaviour are identical in both builds.

## Structure
- **Shared package cdr_pkg:**
  - Vote encoding typedef (2-bit signed: +1/0/−1).
  - Saturating-add function.
  - Default CODE_W and FRAC_W constants, also used by the phase-interpolator model.
- **Sub-module cdr_vote_decim:** vote mapping, window counter, sum and decision output.
- **Top level:** integrator, phase accumulator and lock logic.

## Test plan
All scenarios use default parameters with CDR_LF_INTEGRAL_EN defined unless stated.
- **Reset:** assert rst_n low mid-window while driving up=1 → all outputs 0 immediately, and the first strobe after release comes exactly DECIM cycles plus one edge later.
- **Constant late:** up=1, dn=0, en=1 for 4 windows → freq_int=4, phase_acc=266, pi_code=1, four pi_code_vld pulses 8 cycles apart, lock=0.
- **Wrap-down:** dn=1 for 1 window from reset → freq_int=−1, phase_acc=32703, pi_code=127.
- **Null/tie:** up=dn=1 for a full window, then 4 up and 4 dn → d=0 both windows, pi_code unchanged, pi_code_vld still pulses.
- **Lock:** alternate windows of all-up and all-dn → lock=1 at the 16th decision; two consecutive all-up windows → lock=0 at the second.
- **Freeze and first-order:**
  - en=0 for 5 cycles mid-window → window end slips by exactly 5 cycles.
  - With CDR_LF_INTEGRAL_EN undefined, 4 up windows → freq_int=0, phase_acc=256, pi_code=1.
